fir_tap_scheduler: RTL and testbench

FIR_TAP_SCHEDULER -- requirements
Module: fir_tap_scheduler

---
 rtl/fir_tap_scheduler_if.sv | 40 ++++
 rtl/fir_tap_scheduler.sv | 177 +++++++++++++++++
 tb/tb_fir_tap_scheduler.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_scheduler_if.sv
// ---------------------------------------------------------------------------
// fir_tap_scheduler_if
//   Groups the host coefficient-write handshake and the coefficient RAM port
//   of the FIR tap scheduler.
//
//   Host side (driven by master, sampled by slave):
//     iCoeffUpdReq   level request to enter coefficient-load mode
//     iCoeffWrValid  coefficient write valid
//     iCoeffWrAddr   coefficient RAM write address
//     iCoeffWrData   signed coefficient write data
//   Scheduler side (driven by slave):
//     oCoeffWrReady  scheduler is in coefficient-load mode
//     oCsnRam        RAM chip select, active-low
//     oWrnRam        RAM write enable, active-low
//     oAddrRam       RAM address
//     oWrDtRam       RAM write data
// ---------------------------------------------------------------------------
interface fir_tap_scheduler_if;
  logic               iCoeffUpdReq;
  logic               iCoeffWrValid;
  logic [3:0]         iCoeffWrAddr;
  logic signed [15:0] iCoeffWrData;
  logic               oCoeffWrReady;
  logic               oCsnRam;
  logic               oWrnRam;
  logic [3:0]         oAddrRam;
  logic signed [15:0] oWrDtRam;

  // The scheduler itself.
  modport slave (
    input  iCoeffUpdReq, iCoeffWrValid, iCoeffWrAddr, iCoeffWrData,
    output oCoeffWrReady, oCsnRam, oWrnRam, oAddrRam, oWrDtRam
  );

  // The host / environment.
  modport master (
    output iCoeffUpdReq, iCoeffWrValid, iCoeffWrAddr, iCoeffWrData,
    input  oCoeffWrReady, oCsnRam, oWrnRam, oAddrRam, oWrDtRam
  );
endinterface

// File: rtl/fir_tap_scheduler.sv
// ---------------------------------------------------------------------------
// fir_tap_scheduler
//   Sequences one FIR output sample per input strobe: clears the accumulator,
//   walks the coefficient RAM for N taps, and steers the registered multiplier
//   and accumulator enables so each product lands two cycles after its
//   address. Between samples the host may load coefficients through a
//   same-cycle pass-through onto the RAM port.
//
//   Ports:
//     iClk_12M        12 MHz clock, rising edge
//     iRst            synchronous active-high reset
//     iEnSample_600k  one-cycle sample strobe
//     iNumTaps        configured tap count (0 -> 1, >16 -> 16)
//     bus             host write handshake + coefficient RAM port (slave)
//     oTapSel         delay-line tap select, aligned with RAM read data
//     oEnMul          multiplier enable
//     oClrAcc         accumulator clear
//     oEnAcc          accumulator enable
//     oOutValid       one-cycle pulse: accumulator holds a final sample
//     oBusy           high outside IDLE and LOAD
//     oOverrun        sticky: a strobe arrived when it could not be taken
//
//   Latency is N+4 cycles from strobe to oOutValid:
//     CLEAR(1) + MAC(N) + DRAIN(2) + DONE(1).
// ---------------------------------------------------------------------------
module fir_tap_scheduler (
  input  logic                 iClk_12M,
  input  logic                 iRst,
  input  logic                 iEnSample_600k,
  input  logic [4:0]           iNumTaps,
  fir_tap_scheduler_if.slave   bus,
  output logic [3:0]           oTapSel,
  output logic                 oEnMul,
  output logic                 oClrAcc,
  output logic                 oEnAcc,
  output logic                 oOutValid,
  output logic                 oBusy,
  output logic                 oOverrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_MAC,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e     state_q;
  logic [4:0] n_q;          // effective tap count, frozen for the sample
  logic [3:0] k_q;          // tap counter; doubles as the MAC read address
  logic       drain_q;      // second DRAIN cycle marker
  logic       csn_q;        // RAM select during MAC reads
  logic       en_mul_q;
  logic [3:0] tap_sel_q;
  logic       en_acc_q;
  logic       clr_acc_q;
  logic       out_valid_q;
  logic       busy_q;
  logic       overrun_q;

  function automatic logic [4:0] sat_taps(input logic [4:0] taps);
    if (taps == 5'd0)       return 5'd1;
    else if (taps > 5'd16)  return 5'd16;
    else                    return taps;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state_q     <= S_IDLE;
      n_q         <= 5'd1;
      k_q         <= 4'd0;
      drain_q     <= 1'b0;
      csn_q       <= 1'b1;
      en_mul_q    <= 1'b0;
      tap_sel_q   <= 4'd0;
      en_acc_q    <= 1'b0;
      clr_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // Read pipeline: an address issued this cycle yields RAM data (and the
      // multiplier operand select) next cycle, and a product the cycle after.
      en_mul_q    <= (state_q == S_MAC);
      tap_sel_q   <= (state_q == S_MAC) ? k_q : 4'd0;
      en_acc_q    <= en_mul_q;
      clr_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;

      // Only IDLE can accept a strobe; anywhere else it is lost.
      if (iEnSample_600k && (state_q != S_IDLE))
        overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          // The sample strobe has priority over a pending load request.
          if (iEnSample_600k) begin
            state_q   <= S_CLEAR;
            n_q       <= sat_taps(iNumTaps);
            clr_acc_q <= 1'b1;
            busy_q    <= 1'b1;
          end else if (bus.iCoeffUpdReq) begin
            state_q <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (!bus.iCoeffUpdReq)
            state_q <= S_IDLE;
        end

        S_CLEAR: begin
          state_q <= S_MAC;
          k_q     <= 4'd0;
          csn_q   <= 1'b0;
        end

        S_MAC: begin
          if ({1'b0, k_q} == (n_q - 5'd1)) begin
            state_q <= S_DRAIN;
            k_q     <= 4'd0;
            csn_q   <= 1'b1;
            drain_q <= 1'b0;
          end else begin
            k_q <= k_q + 4'd1;
          end
        end

        S_DRAIN: begin
          if (drain_q) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM port: registered read control during MAC, combinational pass-through
  // of host writes during LOAD so a write lands in the cycle it is presented.
  // NOTE: every output gets a default first so always_comb cannot infer a latch.
  always_comb begin
    bus.oCoeffWrReady = (state_q == S_LOAD);
    bus.oCsnRam       = csn_q;
    bus.oWrnRam       = 1'b1;
    bus.oAddrRam      = k_q;
    bus.oWrDtRam      = 16'sd0;
    if ((state_q == S_LOAD) && bus.iCoeffWrValid) begin
      bus.oCsnRam  = 1'b0;
      bus.oWrnRam  = 1'b0;
      bus.oAddrRam = bus.iCoeffWrAddr;
      bus.oWrDtRam = bus.iCoeffWrData;
    end
  end

  assign oTapSel   = tap_sel_q;
  assign oEnMul    = en_mul_q;
  assign oClrAcc   = clr_acc_q;
  assign oEnAcc    = en_acc_q;
  assign oOutValid = out_valid_q;
  assign oBusy     = busy_q;
  assign oOverrun  = overrun_q;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_scheduler
//   Directed bench for fir_tap_scheduler. Cycle c is the interval after the
//   c-th rising edge following the strobe; inputs are driven 1 ns after the
//   edge and outputs sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_fir_tap_scheduler;

  logic       clk;
  logic       rst;
  logic       strobe;
  logic [4:0] num_taps;
  logic [3:0] tap_sel;
  logic       en_mul, clr_acc, en_acc, out_valid, busy, overrun;

  fir_tap_scheduler_if bus_if ();

  fir_tap_scheduler dut (
    .iClk_12M       (clk),
    .iRst           (rst),
    .iEnSample_600k (strobe),
    .iNumTaps       (num_taps),
    .bus            (bus_if),
    .oTapSel        (tap_sel),
    .oEnMul         (en_mul),
    .oClrAcc        (clr_acc),
    .oEnAcc         (en_acc),
    .oOutValid      (out_valid),
    .oBusy          (busy),
    .oOverrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        csn;
    logic        wrn;
    logic [3:0]  addr;
    logic [15:0] wdt;
    logic [3:0]  tap;
    logic        en_mul;
    logic        clr;
    logic        en_acc;
    logic        valid;
    logic        busy;
    logic        ovr;
  } obs_t;

  typedef struct {
    logic [4:0] taps;
    int         n;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[6];

  function automatic string fmt(input obs_t o);
    return $sformatf("rdy=%0b csn=%0b wrn=%0b addr=%0d wdt=%h tap=%0d mul=%0b clr=%0b acc=%0b vld=%0b busy=%0b ovr=%0b",
                     o.ready, o.csn, o.wrn, o.addr, o.wdt, o.tap, o.en_mul,
                     o.clr, o.en_acc, o.valid, o.busy, o.ovr);
  endfunction

  function automatic obs_t sample_obs();
    obs_t o;
    o.ready  = bus_if.oCoeffWrReady;
    o.csn    = bus_if.oCsnRam;
    o.wrn    = bus_if.oWrnRam;
    o.addr   = bus_if.oAddrRam;
    o.wdt    = bus_if.oWrDtRam;
    o.tap    = tap_sel;
    o.en_mul = en_mul;
    o.clr    = clr_acc;
    o.en_acc = en_acc;
    o.valid  = out_valid;
    o.busy   = busy;
    o.ovr    = overrun;
    return o;
  endfunction

  // Quiet outputs: everything low except the active-low RAM strobes.
  function automatic obs_t idle_obs(input logic ovr);
    obs_t o;
    o     = '0;
    o.csn = 1'b1;
    o.wrn = 1'b1;
    o.ovr = ovr;
    return o;
  endfunction

  // Expected outputs at cycle c of a sample with effective tap count n.
  function automatic obs_t exp_sample(input int n, input int c, input logic ovr);
    obs_t o;
    o      = idle_obs(ovr);
    o.clr  = (c == 1);
    o.busy = (c >= 1) && (c <= n + 4);
    if ((c >= 2) && (c <= n + 1)) begin
      o.csn  = 1'b0;
      o.addr = 4'(c - 2);
    end
    if ((c >= 3) && (c <= n + 2)) begin
      o.en_mul = 1'b1;
      o.tap    = 4'(c - 3);
    end
    o.en_acc = (c >= 4) && (c <= n + 3);
    o.valid  = (c == n + 4);
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One strobed sample, checked cycle by cycle through the IDLE cycle that
  // follows DONE. iNumTaps is scrambled after the strobe to show N is frozen.
  // extra_c >= 0 fires a second strobe at that cycle, which must be dropped
  // and set the overrun flag from the following cycle on.
  task automatic run_sample(input logic [4:0] taps, input int n, input logic ovr0,
                            input logic upd, input int extra_c, input string tag);
    logic ovr;
    next_cycle();
    num_taps            = taps;
    strobe              = 1'b1;
    bus_if.iCoeffUpdReq = upd;
    #1;
    check($sformatf("%s c0", tag), sample_obs(), idle_obs(ovr0));
    for (int c = 1; c <= n + 5; c++) begin
      next_cycle();
      strobe   = (c == extra_c);
      num_taps = ~taps;
      #1;
      ovr = ovr0 | ((extra_c >= 0) && (c > extra_c));
      check($sformatf("%s c%0d", tag, c), sample_obs(), exp_sample(n, c, ovr));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;

    vecs[0] = '{taps: 5'd16, n: 16};
    vecs[1] = '{taps: 5'd0,  n: 1};
    vecs[2] = '{taps: 5'd31, n: 16};
    vecs[3] = '{taps: 5'd1,  n: 1};
    vecs[4] = '{taps: 5'd5,  n: 5};
    vecs[5] = '{taps: 5'd17, n: 16};

    rst                  = 1'b1;
    strobe               = 1'b0;
    num_taps             = 5'd16;
    bus_if.iCoeffUpdReq  = 1'b0;
    bus_if.iCoeffWrValid = 1'b0;
    bus_if.iCoeffWrAddr  = 4'd0;
    bus_if.iCoeffWrData  = 16'sd0;

    // Reset state, held over several edges.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1;
      check($sformatf("reset c%0d", i), sample_obs(), idle_obs(1'b0));
    end
    next_cycle();
    rst = 1'b0;

    // Back-to-back samples at various tap counts, no overrun expected.
    for (int i = 0; i < 6; i++)
      run_sample(vecs[i].taps, vecs[i].n, 1'b0, 1'b0, -1, $sformatf("vec%0d", i));

    // Strobe and load request in the same IDLE cycle: the sample wins, LOAD
    // follows via the IDLE cycle after DONE.
    run_sample(5'd1, 1, 1'b0, 1'b1, -1, "simul");
    next_cycle();
    #1;
    e       = idle_obs(1'b0);
    e.ready = 1'b1;
    check("load_entry", sample_obs(), e);

    // Coefficient writes; a strobe mid-load is dropped and flags overrun;
    // the request drops together with the last write, which still happens.
    for (int a = 0; a < 16; a++) begin
      next_cycle();
      bus_if.iCoeffWrValid = 1'b1;
      bus_if.iCoeffWrAddr  = 4'(a);
      bus_if.iCoeffWrData  = 16'(16'h0100 + a);
      strobe               = (a == 5);
      bus_if.iCoeffUpdReq  = (a != 15);
      #1;
      e       = idle_obs(a > 5);
      e.ready = 1'b1;
      e.csn   = 1'b0;
      e.wrn   = 1'b0;
      e.addr  = 4'(a);
      e.wdt   = 16'(16'h0100 + a);
      check($sformatf("load_wr a%0d", a), sample_obs(), e);
    end
    next_cycle();
    bus_if.iCoeffWrValid = 1'b0;
    strobe               = 1'b0;
    #1;
    check("load_exit", sample_obs(), idle_obs(1'b1));

    // Load mode with no write presented: RAM port quiet.
    next_cycle();
    bus_if.iCoeffUpdReq = 1'b1;
    next_cycle();
    #1;
    e       = idle_obs(1'b1);
    e.ready = 1'b1;
    check("load_idle", sample_obs(), e);
    next_cycle();
    bus_if.iCoeffUpdReq = 1'b0;
    next_cycle();
    #1;
    check("load_idle_exit", sample_obs(), idle_obs(1'b1));

    // Reset clears the sticky overrun; read-back sample walks 0..15.
    rst = 1'b1;
    next_cycle();
    #1;
    check("ovr_reset", sample_obs(), idle_obs(1'b0));
    rst = 1'b0;
    run_sample(5'd16, 16, 1'b0, 1'b0, -1, "readback");

    // Second strobe 20 cycles after the first lands in DONE: dropped, flagged.
    // The flag stays set through a following accepted sample.
    run_sample(5'd16, 16, 1'b0, 1'b0, 20, "done_strobe");
    run_sample(5'd16, 16, 1'b1, 1'b0, -1, "ovr_sticky");

    // Reset during MAC at k=7 aborts the sample and clears overrun.
    next_cycle();
    num_taps = 5'd16;
    strobe   = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      strobe = 1'b0;
      #1;
      check($sformatf("abort c%0d", c), sample_obs(), exp_sample(16, c, 1'b1));
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    check("abort_reset", sample_obs(), idle_obs(1'b0));
    for (int c = 0; c < 24; c++) begin
      next_cycle();
      #1;
      check($sformatf("abort_quiet c%0d", c), sample_obs(), idle_obs(1'b0));
    end
    run_sample(5'd16, 16, 1'b0, 1'b0, -1, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
